// File: rtl/spi_shifter.sv
// SPI bit-level shift engine: serialises one byte MSB first on o_MOSI while
// collecting the byte arriving on i_MISO, in any of the four CPOL/CPHA modes.
// Slave select belongs to the register block above and is not handled here.
module spi_shifter #(
    parameter int DIV_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [7:0]       i_tx_data,
    input  logic             i_cpol,
    input  logic             i_cpha,
    input  logic [DIV_W-1:0] i_clk_div,
    output logic             o_busy,
    output logic             o_done,
    output logic [7:0]       o_rx_data,
    output logic             o_SCLK,
    output logic             o_MOSI,
    input  logic             i_MISO
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [3:0]       edge_cnt_q, edge_cnt_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             cpol_q, cpol_d;
    logic             cpha_q, cpha_d;
    logic [7:0]       tx_sr_q, tx_sr_d;
    logic [7:0]       rx_sr_q, rx_sr_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             done_q, done_d;

    logic             leading;
    logic             sample;
    logic             last_edge;

    // Next-state logic: accept a request in IDLE, then walk 16 SCLK edges,
    // sampling on one edge type and shifting out on the other.
    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        div_cnt_d  = div_cnt_q;
        div_d      = div_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        done_d     = 1'b0;
        leading    = 1'b0;
        sample     = 1'b0;
        last_edge  = 1'b0;

        case (state_q)
            IDLE: begin
                // SCLK tracks the requested idle level while nothing is running.
                sclk_d = i_cpol;
                if (i_start) begin
                    state_d    = SHIFT;
                    cpol_d     = i_cpol;
                    cpha_d     = i_cpha;
                    div_d      = i_clk_div;
                    div_cnt_d  = '0;
                    edge_cnt_d = '0;
                    if (!i_cpha) begin
                        // CPHA=0: bit 7 must already be on the wire before the first edge.
                        mosi_d  = i_tx_data[7];
                        tx_sr_d = {i_tx_data[6:0], 1'b0};
                    end else begin
                        // CPHA=1: bit 7 goes out on the first (leading) edge.
                        tx_sr_d = i_tx_data;
                    end
                end
            end

            SHIFT: begin
                if (div_cnt_q == div_q) begin
                    div_cnt_d  = '0;
                    edge_cnt_d = edge_cnt_q + 4'd1;
                    sclk_d     = ~sclk_q;
                    // edge_cnt_q holds k-1, so even counts are leading edges.
                    leading    = ~edge_cnt_q[0];
                    sample     = leading ^ cpha_q;
                    last_edge  = (edge_cnt_q == 4'd15);

                    if (sample) begin
                        rx_sr_d = {rx_sr_q[6:0], i_MISO};
                    end else if (!last_edge) begin
                        mosi_d  = tx_sr_q[7];
                        tx_sr_d = {tx_sr_q[6:0], 1'b0};
                    end

                    if (last_edge) begin
                        // rx_sr_d already contains a bit sampled on this final edge.
                        state_d   = IDLE;
                        done_d    = 1'b1;
                        rx_data_d = rx_sr_d;
                        sclk_d    = cpol_q;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any transfer without a done pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            div_cnt_q  <= '0;
            div_q      <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            div_cnt_q  <= div_cnt_d;
            div_q      <= div_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            done_q     <= done_d;
        end
    end

    assign o_busy    = (state_q == SHIFT);
    assign o_done    = done_q;
    assign o_rx_data = rx_data_q;
    assign o_SCLK    = sclk_q;
    assign o_MOSI    = mosi_q;

endmodule

// File: tb/tb_spi_shifter.sv
// Directed bench for spi_shifter: SPI modes 0/1/3, divider values, ignored
// requests, reset abort and back-to-back streaming.
module tb_spi_shifter;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] tx_data;
    logic       cpol;
    logic       cpha;
    logic [4:0] clk_div;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic       sclk;
    logic       mosi;
    logic       loop_en;
    logic       miso_drv;
    wire        miso = loop_en ? mosi : miso_drv;

    int vec_cnt = 0;
    int err_cnt = 0;

    spi_shifter #(.DIV_W(5)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_tx_data (tx_data),
        .i_cpol    (cpol),
        .i_cpha    (cpha),
        .i_clk_div (clk_div),
        .o_busy    (busy),
        .o_done    (done),
        .o_rx_data (rx_data),
        .o_SCLK    (sclk),
        .o_MOSI    (mosi),
        .i_MISO    (miso)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one transfer and measures it; the calling test judges the results.
    // pat is driven on MISO, one bit after each leading edge, when loop is 0.
    task automatic xfer(input logic [7:0] data, input logic pol, input logic pha,
                        input logic [4:0] div, input logic loop, input logic [7:0] pat,
                        output int busy_cyc, output int rises,
                        output int chg_rise, output int chg_fall,
                        output logic [7:0] mosi_byte, output logic idle_sclk,
                        output logic done_after, output logic timed_out);
        logic prev_sclk, prev_mosi;
        int   lead_n;
        busy_cyc  = 0; rises = 0; chg_rise = 0; chg_fall = 0;
        mosi_byte = 8'h00; timed_out = 1'b1; lead_n = 0;
        cpol = pol; cpha = pha; clk_div = div; tx_data = data;
        loop_en = loop; miso_drv = pat[7];
        tick();
        idle_sclk = sclk;
        start = 1'b1;
        tick();
        start = 1'b0;
        prev_sclk = sclk;
        prev_mosi = mosi;
        for (int c = 0; c < 2000; c++) begin
            if (sclk !== prev_sclk) begin
                if (sclk) rises++;
                if (mosi !== prev_mosi) begin
                    if (sclk) chg_rise++; else chg_fall++;
                end
                if ((sclk !== pol) == !pha)
                    mosi_byte = {mosi_byte[6:0], mosi};
                if (sclk !== pol) begin
                    if (lead_n < 8) miso_drv = pat[7-lead_n];
                    lead_n++;
                end
            end
            if (busy) busy_cyc++;
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            prev_sclk = sclk;
            prev_mosi = mosi;
            tick();
        end
        tick();
        done_after = done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %b want 0", busy); end
        vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL reset_done got %b want 0", done); end
        vec_cnt++; if (rx_data !== 8'h00) begin err_cnt++; $display("FAIL reset_rx got %h want 00", rx_data); end
        vec_cnt++; if (sclk !== 1'b0) begin err_cnt++; $display("FAIL reset_sclk got %b want 0", sclk); end
        vec_cnt++; if (mosi !== 1'b0) begin err_cnt++; $display("FAIL reset_mosi got %b want 0", mosi); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_mode0();
        int b, r, cr, cf; logic [7:0] mb; logic is, da, to;
        xfer(8'hA5, 1'b0, 1'b0, 5'd0, 1'b1, 8'h00, b, r, cr, cf, mb, is, da, to);
        vec_cnt++; if (to !== 1'b0) begin err_cnt++; $display("FAIL m0_timeout got %b want 0", to); end
        vec_cnt++; if (b != 16) begin err_cnt++; $display("FAIL m0_busy_cycles got %0d want 16", b); end
        vec_cnt++; if (r != 8) begin err_cnt++; $display("FAIL m0_sclk_rises got %0d want 8", r); end
        vec_cnt++; if (da !== 1'b0) begin err_cnt++; $display("FAIL m0_done_width got %b want 0", da); end
        vec_cnt++; if (rx_data !== 8'hA5) begin err_cnt++; $display("FAIL m0_rx got %h want a5", rx_data); end
        vec_cnt++; if (mb !== 8'hA5) begin err_cnt++; $display("FAIL m0_mosi_bits got %h want a5", mb); end
    endtask

    task automatic test_mode3();
        int b, r, cr, cf; logic [7:0] mb; logic is, da, to;
        xfer(8'h3C, 1'b1, 1'b1, 5'd3, 1'b0, 8'hFF, b, r, cr, cf, mb, is, da, to);
        vec_cnt++; if (to !== 1'b0) begin err_cnt++; $display("FAIL m3_timeout got %b want 0", to); end
        vec_cnt++; if (is !== 1'b1) begin err_cnt++; $display("FAIL m3_idle_sclk got %b want 1", is); end
        vec_cnt++; if (b != 64) begin err_cnt++; $display("FAIL m3_busy_cycles got %0d want 64", b); end
        vec_cnt++; if (mb !== 8'h3C) begin err_cnt++; $display("FAIL m3_mosi_bits got %h want 3c", mb); end
        vec_cnt++; if (cr != 0 || cf != 3) begin err_cnt++; $display("FAIL m3_mosi_edges got rise=%0d fall=%0d want rise=0 fall=3", cr, cf); end
        vec_cnt++; if (rx_data !== 8'hFF) begin err_cnt++; $display("FAIL m3_rx got %h want ff", rx_data); end
        vec_cnt++; if (sclk !== 1'b1) begin err_cnt++; $display("FAIL m3_sclk_end got %b want 1", sclk); end
    endtask

    task automatic test_mode1();
        int b, r, cr, cf; logic [7:0] mb; logic is, da, to;
        xfer(8'h5A, 1'b0, 1'b1, 5'd1, 1'b0, 8'h81, b, r, cr, cf, mb, is, da, to);
        vec_cnt++; if (to !== 1'b0) begin err_cnt++; $display("FAIL m1_timeout got %b want 0", to); end
        vec_cnt++; if (b != 32) begin err_cnt++; $display("FAIL m1_busy_cycles got %0d want 32", b); end
        vec_cnt++; if (rx_data !== 8'h81) begin err_cnt++; $display("FAIL m1_rx got %h want 81", rx_data); end
        vec_cnt++; if (mb !== 8'h5A) begin err_cnt++; $display("FAIL m1_mosi_bits got %h want 5a", mb); end
        vec_cnt++; if (cf != 0 || cr == 0) begin err_cnt++; $display("FAIL m1_mosi_edges got rise=%0d fall=%0d want rise>0 fall=0", cr, cf); end
    endtask

    task automatic test_ignore_start();
        int ndone, done_idx; logic busy20;
        ndone = 0; done_idx = -1; busy20 = 1'bx;
        cpol = 1'b0; cpha = 1'b0; clk_div = 5'd0; tx_data = 8'hC3; loop_en = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int idx = 0; idx < 30; idx++) begin
            if (idx == 5) begin start = 1'b1; clk_div = 5'd7; tx_data = 8'h00; end
            if (idx == 6) start = 1'b0;
            if (idx == 20) busy20 = busy;
            if (done) begin ndone++; done_idx = idx; end
            tick();
        end
        clk_div = 5'd0;
        vec_cnt++; if (ndone != 1) begin err_cnt++; $display("FAIL ign_done_count got %0d want 1", ndone); end
        vec_cnt++; if (done_idx != 16) begin err_cnt++; $display("FAIL ign_done_cycle got %0d want 16", done_idx); end
        vec_cnt++; if (busy20 !== 1'b0) begin err_cnt++; $display("FAIL ign_busy_after got %b want 0", busy20); end
        vec_cnt++; if (rx_data !== 8'hC3) begin err_cnt++; $display("FAIL ign_rx got %h want c3", rx_data); end
    endtask

    task automatic test_reset_abort();
        int edges, ndone; logic prev;
        int b, r, cr, cf; logic [7:0] mb; logic is, da, to;
        edges = 0; ndone = 0;
        cpol = 1'b1; cpha = 1'b0; clk_div = 5'd1; tx_data = 8'h6E; loop_en = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        prev = sclk;
        for (int c = 0; c < 200 && edges < 5; c++) begin
            tick();
            if (sclk !== prev) edges++;
            prev = sclk;
        end
        vec_cnt++; if (edges != 5) begin err_cnt++; $display("FAIL abort_edges got %0d want 5", edges); end
        rst = 1'b1;
        #1;
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL abort_busy got %b want 0", busy); end
        vec_cnt++; if (sclk !== 1'b0) begin err_cnt++; $display("FAIL abort_sclk got %b want 0", sclk); end
        vec_cnt++; if (rx_data !== 8'h00) begin err_cnt++; $display("FAIL abort_rx got %h want 00", rx_data); end
        tick();
        rst = 1'b0;
        tick();
        vec_cnt++; if (sclk !== 1'b1) begin err_cnt++; $display("FAIL abort_sclk_reload got %b want 1", sclk); end
        for (int c = 0; c < 40; c++) begin
            if (done) ndone++;
            tick();
        end
        vec_cnt++; if (ndone != 0) begin err_cnt++; $display("FAIL abort_no_done got %0d want 0", ndone); end
        xfer(8'h96, 1'b0, 1'b0, 5'd0, 1'b1, 8'h00, b, r, cr, cf, mb, is, da, to);
        vec_cnt++; if (to !== 1'b0 || b != 16) begin err_cnt++; $display("FAIL abort_next_busy got %0d to=%b want 16 to=0", b, to); end
        vec_cnt++; if (rx_data !== 8'h96) begin err_cnt++; $display("FAIL abort_next_rx got %h want 96", rx_data); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [3];
        int n;
        logic busy17;
        vals[0] = 8'h11; vals[1] = 8'hE7; vals[2] = 8'h5C;
        n = 0; busy17 = 1'bx;
        cpol = 1'b0; cpha = 1'b0; clk_div = 5'd0; tx_data = vals[0]; loop_en = 1'b1;
        tick();
        start = 1'b1;
        tick();
        for (int idx = 0; idx < 80 && n < 3; idx++) begin
            if (idx == 17) busy17 = busy;
            if (done) begin
                vec_cnt++; if (idx != 16 + 17 * n) begin err_cnt++; $display("FAIL b2b_done_cycle[%0d] got %0d want %0d", n, idx, 16 + 17 * n); end
                vec_cnt++; if (rx_data !== vals[n]) begin err_cnt++; $display("FAIL b2b_rx[%0d] got %h want %h", n, rx_data, vals[n]); end
                n++;
                if (n < 3) tx_data = vals[n];
                else start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        vec_cnt++; if (n != 3) begin err_cnt++; $display("FAIL b2b_count got %0d want 3", n); end
        vec_cnt++; if (busy17 !== 1'b1) begin err_cnt++; $display("FAIL b2b_no_gap got %b want 1", busy17); end
    endtask

    initial begin
        start = 1'b0; tx_data = 8'h00; cpol = 1'b0; cpha = 1'b0;
        clk_div = 5'd0; loop_en = 1'b0; miso_drv = 1'b0; rst = 1'b0;
        test_reset();
        test_mode0();
        test_mode3();
        test_mode1();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/spi_shifter.md
SPI_SHIFTER -- requirements
Module: spi_shifter

Interface
REQ-001 Parameter DIV_W, default 5, width of the clock-divisor input.
REQ-002 i_clk  input  1  system clock; all state on its rising edge.
REQ-003 i_rst  input  1  reset, asynchronous, active-high.
REQ-004 i_start  input  1  request one 8-bit transfer.
REQ-005 i_tx_data  input  8  byte to send, MSB first.
REQ-006 i_cpol  input  1  SPI clock polarity, idle SCLK level.
REQ-007 i_cpha  input  1  SPI clock phase.
REQ-008 i_clk_div  input  DIV_W  half-period of SCLK, minus one, in i_clk cycles.
REQ-009 o_busy  output  1  transfer in progress.
REQ-010 o_done  output  1  one-cycle pulse at end of transfer.
REQ-011 o_rx_data  output  8  last received byte.
REQ-012 o_SCLK  output  1  SPI clock to pin.
REQ-013 o_MOSI  output  1  serial data out.
REQ-014 i_MISO  input  1  serial data in.

Function
REQ-015 The block shall be the bit-level shift engine beneath the SPI master register block: it serialises a byte and returns the received byte; slave select is not driven here.
REQ-016 The block shall have two states, IDLE and SHIFT, plus a 4-bit edge counter (0..15) and a DIV_W-bit divider counter.
REQ-017 Acceptance edge T0 shall be a rising i_clk edge with i_start=1 and o_busy=0; at T0 the block shall latch i_tx_data, i_cpol, i_cpha, i_clk_div (D), clear the counters, enter SHIFT, and set o_busy=1.
REQ-018 i_start while o_busy=1 shall be ignored; input changes during SHIFT shall have no effect on the transfer.
REQ-019 In IDLE, o_SCLK shall be registered from i_cpol every cycle.
REQ-020 In SHIFT, o_SCLK shall toggle at edges T0+k*(D+1), k=1..16: odd k are leading edges, even k are trailing edges; after k=16, o_SCLK equals latched CPOL.
REQ-021 With CPHA=0, o_MOSI shall present bit 7 at T0; sampling shall occur on leading edges; trailing edges k=2,4,..,14 shall shift out the next bit.
REQ-022 With CPHA=1, leading edges shall shift out bits 7..0 (bit 7 at k=1); sampling shall occur on trailing edges.
REQ-023 Sampling shall capture i_MISO at that i_clk edge into the receive shift register, MSB first; no input synchroniser.
REQ-024 At T0+16*(D+1) the block shall return to IDLE with o_busy=0, assert o_done for exactly one cycle, and load o_rx_data with the 8 sampled bits, including a bit sampled at that same edge.
REQ-025 o_rx_data shall hold until the next o_done.
REQ-026 o_MOSI shall hold the last bit shifted out until the next acceptance.
REQ-027 Transfer length shall be exactly 16*(D+1) cycles; D=0 gives SCLK = i_clk/2; D=2^DIV_W-1 shall be legal.
REQ-028 Back-to-back: i_start high in the o_done cycle shall be accepted at the next edge, with zero idle cycles beyond that.

Reset
REQ-029 On i_rst=1, asynchronously: state=IDLE, o_busy=0, o_done=0, o_rx_data=8'h00, o_SCLK=0, o_MOSI=0, counters=0.
REQ-030 Reset asserted mid-transfer shall abort it with no o_done pulse; the first cycle after release shall load o_SCLK from i_cpol.

Verification
REQ-031 Mode 0, D=0, i_tx_data=8'hA5, i_MISO looped to o_MOSI -> o_busy high 16 cycles, 8 rising SCLK edges, o_done one cycle, o_rx_data=8'hA5.
REQ-032 Mode 3, D=3, i_tx_data=8'h3C, i_MISO=1 -> SCLK idles high, 64-cycle transfer, MOSI bits 0,0,1,1,1,1,0,0 change on falling SCLK, o_rx_data=8'hFF.
REQ-033 Mode 1, D=1, i_MISO driven 8'h81 MSB first on each leading edge -> o_rx_data=8'h81 at o_done, MOSI changes on leading edges.
REQ-034 i_start pulsed and i_clk_div changed to 7 at cycle 5 of a D=0 transfer -> ignored, transfer still ends at T0+16, one o_done only.
REQ-035 i_rst pulsed after 5th SCLK edge -> o_busy=0, o_SCLK=0, o_rx_data=00 immediately, no o_done, next transfer correct.
REQ-036 i_start held high continuously, D=0 -> transfers every 17 cycles (16 busy + 1 done), each o_rx_data correct.
